// File: rtl/exec_unit.sv
// ---------------------------------------------------------------------------
// exec_unit -- integer execute stage: single-cycle ALU plus an M-extension
// unit (two-cycle multiplier, 34-cycle restoring divider).
//
// Ports
//   CLK        rising-edge clock
//   RESET      synchronous active-high reset
//   IN_VALID   operation presented this cycle
//   IN_READY   block can accept an operation this cycle (only when idle)
//   ALU_CTRL   ALU operation code (ignored when MDU_EN=1)
//   MDU_EN     selects an M-extension operation coded by FUNC3
//   FUNC3      MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   DATA1      operand A (rs1)
//   DATA2      operand B (rs2 or immediate)
//   RESULT     registered result, held between OUT_VALID pulses
//   OUT_VALID  one-cycle pulse per accepted operation
//   ILLEGAL    pulses with OUT_VALID for an undefined ALU_CTRL code
// ---------------------------------------------------------------------------
module exec_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  ALU_CTRL,
    input  logic        MDU_EN,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    output logic [31:0] RESULT,
    output logic        OUT_VALID,
    output logic        ILLEGAL
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    // Control registers (reset)
    state_t              state_q;
    logic [DATA_W-1:0]   result_q;
    logic                out_valid_q;
    logic                illegal_q;
    logic [4:0]          cnt_q;

    // Datapath registers (no reset)
    logic [1:0]          op_q;        // FUNC3[1:0] of the accepted M op
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   dvsr_q;
    logic [DATA_W-1:0]   quo_q;       // dividend shifts out as quotient shifts in
    logic [DATA_W-1:0]   rem_q;
    logic                qneg_q;
    logic                rneg_q;
    logic                spec_q;      // divide-by-zero / overflow shortcut
    logic [DATA_W-1:0]   spec_val_q;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                 input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        return neg_if(v, is_signed & v[DATA_W-1]);
    endfunction

    logic accept;
    assign accept   = IN_VALID && (state_q == S_IDLE);
    assign IN_READY = (state_q == S_IDLE);

    // ---------------- ALU ----------------
    logic signed [DATA_W-1:0] a_s, b_s;
    logic [DATA_W-1:0]        alu_res_d;
    logic                     alu_ill_d;

    assign a_s = DATA1;
    assign b_s = DATA2;

    always_comb begin
        alu_res_d = '0;
        alu_ill_d = 1'b0;
        case (ALU_CTRL)
            4'b0000: alu_res_d = DATA1 & DATA2;
            4'b0001: alu_res_d = DATA1 | DATA2;
            4'b0010: alu_res_d = DATA1 + DATA2;
            4'b0011: alu_res_d = DATA1 - DATA2;
            4'b0100: alu_res_d = DATA1 << DATA2[4:0];
            4'b0101: alu_res_d = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            4'b0110: alu_res_d = {{(DATA_W-1){1'b0}}, (DATA1 < DATA2)};
            4'b0111: alu_res_d = DATA1 ^ DATA2;
            4'b1000: alu_res_d = DATA1 >> DATA2[4:0];
            4'b1001: alu_res_d = a_s >>> DATA2[4:0];
            default: alu_ill_d = 1'b1;
        endcase
    end

    // ---------------- Multiplier operands ----------------
    // Operands are extended to 64 bits according to signedness, so a single
    // 64-bit product yields the correct low and high halves for every variant.
    logic                       mul_a_sgn, mul_b_sgn;
    logic signed [2*DATA_W-1:0] mul_a, mul_b, prod_d;

    assign mul_a_sgn = (FUNC3[1:0] == 2'b01) || (FUNC3[1:0] == 2'b10);
    assign mul_b_sgn = (FUNC3[1:0] == 2'b01);
    assign mul_a     = {{DATA_W{mul_a_sgn & DATA1[DATA_W-1]}}, DATA1};
    assign mul_b     = {{DATA_W{mul_b_sgn & DATA2[DATA_W-1]}}, DATA2};
    assign prod_d    = mul_a * mul_b;

    // ---------------- Divider setup ----------------
    logic              div_sgn, div_rem, div_zero, div_ovf, div_spec;
    logic [DATA_W-1:0] spec_val_d;

    assign div_sgn  = ~FUNC3[0];
    assign div_rem  = FUNC3[1];
    assign div_zero = (DATA2 == '0);
    assign div_ovf  = div_sgn && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
    assign div_spec = div_zero || div_ovf;

    always_comb begin
        spec_val_d = '0;
        if (div_zero)
            spec_val_d = div_rem ? DATA1 : '1;
        else
            spec_val_d = div_rem ? '0 : 32'h8000_0000;
    end

    // ---------------- Restoring division step ----------------
    logic [DATA_W:0]   rem_shift, diff;
    logic [DATA_W-1:0] rem_d, quo_d;

    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, dvsr_q};
    assign rem_d     = diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_d     = {quo_q[DATA_W-2:0], ~diff[DATA_W]};

    // ---------------- Result selection for MUL / FIX ----------------
    logic [DATA_W-1:0] mul_res_d, fix_res_d;

    assign mul_res_d = (op_q == 2'b00) ? prod_q[DATA_W-1:0] : prod_q[2*DATA_W-1:DATA_W];
    assign fix_res_d = spec_q  ? spec_val_q :
                       op_q[1] ? neg_if(rem_q, rneg_q) : neg_if(quo_q, qneg_q);

    // ---------------- Control FSM with registered outputs ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (!MDU_EN) begin
                            result_q    <= alu_res_d;
                            out_valid_q <= 1'b1;
                            illegal_q   <= alu_ill_d;
                        end else if (!FUNC3[2]) begin
                            state_q <= S_MUL;
                        end else if (div_spec) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_DIV;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_MUL: begin
                    result_q    <= mul_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_DIV: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q    <= fix_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (accept && MDU_EN) begin
            op_q       <= FUNC3[1:0];
            prod_q     <= prod_d;
            dvsr_q     <= magnitude(DATA2, div_sgn);
            quo_q      <= magnitude(DATA1, div_sgn);
            rem_q      <= '0;
            qneg_q     <= div_sgn & (DATA1[DATA_W-1] ^ DATA2[DATA_W-1]);
            rneg_q     <= div_sgn & DATA1[DATA_W-1];
            spec_q     <= div_spec;
            spec_val_q <= spec_val_d;
        end else if (state_q == S_DIV) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign RESULT    = result_q;
    assign OUT_VALID = out_valid_q;
    assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_unit -- directed and randomized checks of exec_unit against a
// behavioural model built from 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_exec_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  ALU_CTRL;
    logic        MDU_EN;
    logic [2:0]  FUNC3;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [31:0] RESULT;
    logic        OUT_VALID;
    logic        ILLEGAL;

    int checks = 0;
    int errors = 0;

    exec_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .ALU_CTRL  (ALU_CTRL),
        .MDU_EN    (MDU_EN),
        .FUNC3     (FUNC3),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .RESULT    (RESULT),
        .OUT_VALID (OUT_VALID),
        .ILLEGAL   (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: result, illegal flag and latency straight from the
    // instruction semantics using wide integer arithmetic.
    function automatic void model(input logic mdu, input logic [3:0] ctrl,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic ill, output int lat);
        longint    sa, sb, ua, ub, p;
        logic [63:0] up;
        logic [4:0]  sh;
        logic        sgn, rem;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        sh  = b[4:0];
        res = '0;
        ill = 1'b0;
        lat = 1;
        if (!mdu) begin
            case (ctrl)
                4'd0: res = a & b;
                4'd1: res = a | b;
                4'd2: res = 32'(ua + ub);
                4'd3: res = 32'(ua - ub);
                4'd4: res = 32'(ua << sh);
                4'd5: res = (sa < sb) ? 32'd1 : 32'd0;
                4'd6: res = (ua < ub) ? 32'd1 : 32'd0;
                4'd7: res = a ^ b;
                4'd8: res = 32'(ua >> sh);
                4'd9: res = 32'(sa >>> sh);
                default: ill = 1'b1;
            endcase
        end else if (!f3[2]) begin
            lat = 2;
            case (f3[1:0])
                2'd0: begin p = sa * sb; res = p[31:0];  end
                2'd1: begin p = sa * sb; res = p[63:32]; end
                2'd2: begin p = sa * ub; res = p[63:32]; end
                default: begin up = 64'(ua) * 64'(ub); res = up[63:32]; end
            endcase
        end else begin
            sgn = ~f3[0];
            rem = f3[1];
            if (b == 32'd0) begin
                lat = 2;
                res = rem ? a : 32'hFFFF_FFFF;
            end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lat = 2;
                res = rem ? 32'd0 : 32'h8000_0000;
            end else begin
                lat = 34;
                if (sgn) res = rem ? 32'(sa % sb) : 32'(sa / sb);
                else     res = rem ? 32'(ua % ub) : 32'(ua / ub);
            end
        end
    endfunction

    // Issue one operation from idle, then watch the outputs until OUT_VALID.
    task automatic run_op(input logic mdu, input logic [3:0] ctrl, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input string tag,
                          output logic [31:0] got);
        logic [31:0] er, prev;
        logic        ei;
        int          el, n;
        logic        rdy_bad, hold_bad;
        model(mdu, ctrl, f3, a, b, er, ei, el);
        @(negedge CLK);
        check({tag, "_ready"}, {31'b0, IN_READY}, 32'd1);
        MDU_EN   = mdu;
        ALU_CTRL = ctrl;
        FUNC3    = f3;
        DATA1    = a;
        DATA2    = b;
        IN_VALID = 1'b1;
        prev     = RESULT;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        DATA1    = $urandom;
        DATA2    = $urandom;
        ALU_CTRL = 4'($urandom);
        FUNC3    = 3'($urandom);
        MDU_EN   = 1'($urandom);
        n        = 0;
        rdy_bad  = 1'b0;
        hold_bad = 1'b0;
        do begin
            @(negedge CLK);
            n++;
            if (!OUT_VALID) begin
                if (IN_READY) rdy_bad = 1'b1;
                if (RESULT !== prev) hold_bad = 1'b1;
            end
        end while (!OUT_VALID && n < 40);
        got = RESULT;
        check({tag, "_latency"}, 32'(n), 32'(el));
        check({tag, "_result"}, RESULT, er);
        check({tag, "_illegal"}, {31'b0, ILLEGAL}, {31'b0, ei});
        check({tag, "_hold"}, {31'b0, hold_bad}, 32'd0);
        if (el > 1) check({tag, "_busy"}, {31'b0, rdy_bad}, 32'd0);
        @(negedge CLK);
        check({tag, "_pulse"}, {31'b0, OUT_VALID}, 32'd0);
    endtask

    logic [3:0]  bc[4];
    logic [31:0] ba[4], bb[4], be[4];
    logic [31:0] got;
    logic        seen;

    initial begin
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        ALU_CTRL = '0;
        MDU_EN   = 1'b0;
        FUNC3    = '0;
        DATA1    = '0;
        DATA2    = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_result", RESULT, 32'd0);
        check("rst_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_illegal", {31'b0, ILLEGAL}, 32'd0);
        check("rst_ready", {31'b0, IN_READY}, 32'd1);
        RESET = 1'b0;

        // Back-to-back ALU: ADD, SUB, SRA, SLTU
        bc = '{4'd2, 4'd3, 4'd9, 4'd6};
        ba = '{32'd7, 32'd7, 32'h8000_0000, 32'd1};
        bb = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd4, 32'd2};
        be = '{32'd4, 32'd10, 32'hF800_0000, 32'd1};
        @(negedge CLK);
        MDU_EN = 1'b0;
        ALU_CTRL = bc[0]; DATA1 = ba[0]; DATA2 = bb[0]; IN_VALID = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            check($sformatf("b2b%0d_valid", i - 1), {31'b0, OUT_VALID}, 32'd1);
            check($sformatf("b2b%0d_result", i - 1), RESULT, be[i - 1]);
            check($sformatf("b2b%0d_ready", i - 1), {31'b0, IN_READY}, 32'd1);
            if (i < 4) begin
                ALU_CTRL = bc[i]; DATA1 = ba[i]; DATA2 = bb[i];
            end else begin
                IN_VALID = 1'b0;
            end
        end

        // Directed multiply / divide / illegal cases
        run_op(1'b1, 4'd0, 3'b001, 32'hFFFF_FFFF, 32'd2, "mulh", got);
        check("mulh_const", got, 32'hFFFF_FFFF);
        run_op(1'b1, 4'd0, 3'b011, 32'hFFFF_FFFF, 32'd2, "mulhu", got);
        check("mulhu_const", got, 32'd1);
        run_op(1'b1, 4'd0, 3'b100, 32'hFFFF_FFF9, 32'd2, "div", got);
        check("div_const", got, 32'hFFFF_FFFD);
        run_op(1'b1, 4'd0, 3'b110, 32'hFFFF_FFF9, 32'd2, "rem", got);
        check("rem_const", got, 32'hFFFF_FFFF);
        run_op(1'b1, 4'd0, 3'b101, 32'd5, 32'd0, "divu0", got);
        check("divu0_const", got, 32'hFFFF_FFFF);
        run_op(1'b1, 4'd0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "removf", got);
        check("removf_const", got, 32'd0);
        run_op(1'b1, 4'd0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "divovf", got);
        run_op(1'b1, 4'd0, 3'b111, 32'd1234, 32'd0, "remu0", got);
        run_op(1'b1, 4'd0, 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu", got);
        run_op(1'b0, 4'b1111, 3'b000, 32'd9, 32'd9, "illegal", got);
        check("illegal_const", got, 32'd0);

        // Reset during a division aborts it
        @(negedge CLK);
        MDU_EN = 1'b1; FUNC3 = 3'b100; DATA1 = 32'd1000; DATA2 = 32'd7; IN_VALID = 1'b1;
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_ready", {31'b0, IN_READY}, 32'd1);
        check("abort_result", RESULT, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (OUT_VALID) seen = 1'b1;
        end
        check("abort_no_valid", {31'b0, seen}, 32'd0);
        run_op(1'b0, 4'd2, 3'b000, 32'd1, 32'd1, "post_reset_add", got);
        check("post_reset_add_const", got, 32'd2);

        // Reset wins over a simultaneous IN_VALID
        @(negedge CLK);
        MDU_EN = 1'b0; ALU_CTRL = 4'd2; DATA1 = 32'd5; DATA2 = 32'd5;
        IN_VALID = 1'b1; RESET = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0; RESET = 1'b0;
        check("rst_prio_valid", {31'b0, OUT_VALID}, 32'd0);
        check("rst_prio_result", RESULT, 32'd0);
        @(negedge CLK);
        check("rst_prio_late", {31'b0, OUT_VALID}, 32'd0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            logic        rm;
            logic [3:0]  rc;
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            rm = 1'($urandom);
            rc = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) rc = 4'hF;
            rf = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 17));
                3: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(rm, rc, rf, ra, rb, $sformatf("rnd%0d", k), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: CLK  input  1  rising-edge clock.
REQ-003 Port: RESET  input  1  synchronous active-high reset.
REQ-004 Port: IN_VALID  input  1  operation presented this cycle.
REQ-005 Port: IN_READY  output  1  block can accept an operation this cycle.
REQ-006 Port: ALU_CTRL  input  4  ALU operation code from the ALU control stage.
REQ-007 Port: MDU_EN  input  1  M-extension operation; when high, FUNC3 selects the operation and ALU_CTRL is ignored.
REQ-008 Port: FUNC3  input  3  M-extension operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 Port: DATA1  input  32  operand A (rs1).
REQ-010 Port: DATA2  input  32  operand B (rs2 or immediate).
REQ-011 Port: RESULT  output  32  registered result.
REQ-012 Port: OUT_VALID  output  1  RESULT is valid this cycle; one-cycle pulse per accepted operation.
REQ-013 Port: ILLEGAL  output  1  pulses with OUT_VALID when the accepted ALU_CTRL was not a defined code.

Function
REQ-014 ALU codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SLT, 0110 SLTU, 0111 XOR, 1000 SRL, 1001 SRA.
REQ-015 Shifts SHALL use DATA2[4:0] only; SLT/SLTU SHALL return 32'd1 or 32'd0; ADD/SUB SHALL wrap modulo 2^32.
REQ-016 Any other ALU_CTRL with MDU_EN=0 SHALL produce RESULT=0 and OUT_VALID=1 with ILLEGAL=1, at ALU latency.
REQ-017 Acceptance SHALL occur on a rising edge where IN_VALID=1, IN_READY=1 and RESET=0; inputs need only be stable during that cycle.
REQ-018 IN_VALID while IN_READY=0 SHALL be ignored; upstream holds the operation.
REQ-019 States: IDLE, MUL, DIV, FIX; IN_READY SHALL be 1 only in IDLE.
REQ-020 ALU operation: computed and registered at the acceptance edge; OUT_VALID high in the next cycle; state stays IDLE, so back-to-back ALU ops yield one result per cycle.
REQ-021 MUL group: IDLE->MUL at acceptance; the 64-bit product is registered in MUL; MUL->IDLE on the next edge with OUT_VALID=1 (latency 2).
REQ-022 MUL returns product[31:0]; MULH signed x signed [63:32]; MULHSU signed DATA1 x unsigned DATA2 [63:32]; MULHU unsigned x unsigned [63:32].
REQ-023 DIV group: IDLE->DIV at acceptance; operand magnitudes are latched (signed ops only), along with the result signs.
REQ-024 DIV state: restoring division, one quotient bit per cycle, with a 5-bit counter running for exactly 32 cycles; then DIV->FIX.
REQ-025 FIX state: apply signs (quotient negative iff operand signs differ; remainder takes the dividend sign), register RESULT, assert OUT_VALID, then FIX->IDLE; total latency 34 cycles.
REQ-026 Divide by zero: DIV/DIVU return 32'hFFFFFFFF and REM/REMU return DATA1; these go IDLE->FIX directly (latency 2).
REQ-027 Signed overflow (DATA1=32'h80000000, DATA2=32'hFFFFFFFF): DIV returns 32'h80000000 and REM returns 0, via IDLE->FIX (latency 2).
REQ-028 RESULT SHALL hold its last value when OUT_VALID=0.
REQ-029 Exactly one OUT_VALID pulse SHALL occur per accepted operation, in acceptance order.

Reset
REQ-030 While RESET=1 on an edge: state IDLE, RESULT=0, OUT_VALID=0, ILLEGAL=0, division counter=0; IN_READY=1 in the following cycle.
REQ-031 RESET mid-MUL or mid-DIV SHALL abort the operation with no OUT_VALID for it; RESET takes priority over a simultaneous IN_VALID.

Verification
REQ-032 ADD 7+(-3), then SUB, SRA 32'h80000000>>4, SLTU 1<2 on consecutive cycles -> 4, 10, 32'hF8000000, 1, each one cycle after acceptance, no gaps.
REQ-033 MULH DATA1=32'hFFFFFFFF (-1), DATA2=2 -> RESULT 32'hFFFFFFFF, OUT_VALID two cycles after acceptance; MULHU same operands -> 1.
REQ-034 DIV -7/2 -> -3 (32'hFFFFFFFD); REM -7/2 -> -1; each with OUT_VALID 34 cycles after acceptance and IN_READY=0 throughout.
REQ-035 DIVU 5/0 -> 32'hFFFFFFFF; REM 32'h80000000 / 32'hFFFFFFFF -> 0; both at latency 2.
REQ-036 RESET asserted at division cycle 10 -> no OUT_VALID, IN_READY=1 the next cycle; a following ADD 1+1 -> 2.
REQ-037 ALU_CTRL=1111, MDU_EN=0 -> RESULT=0, OUT_VALID=1, ILLEGAL=1, one cycle after acceptance.
